// File: rtl/frame_cipher_ctrl_pkg.sv
// Shared types and sizing helpers for the Lorenz-keyed frame cipher controller.
package enc_pkg;
  localparam int DW            = 8;
  localparam int HDR_BYTES_DEF = 54;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    PIX   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int FRAME_BYTES(input int w, input int h, input int bpp, input int hdr);
    return hdr + w * h * bpp;
  endfunction
endpackage

// File: rtl/frame_cipher_ctrl_if.sv
// Stream bundle for the cipher controller: pixel input (s_*), keystream input (k_*), output (m_*).
// Handshake: a beat moves on a rising clk edge where tvalid & tready are both high; a source holds tdata/tvalid until it moves.
interface frame_cipher_ctrl_if import enc_pkg::*; #(parameter int WIDTH = DW) ();
  logic [WIDTH-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [WIDTH-1:0] k_tdata;
  logic             k_tvalid;
  logic             k_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  // master: the environment around the controller (sources and sink)
  modport master (
    output s_tdata, s_tvalid, k_tdata, k_tvalid, m_tready,
    input  s_tready, k_tready, m_tdata, m_tvalid, m_tlast
  );

  // slave: the controller itself
  modport slave (
    input  s_tdata, s_tvalid, k_tdata, k_tvalid, m_tready,
    output s_tready, k_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/frame_cipher_ctrl_axis_out_reg.sv
// One-deep registered output stage carrying data and last; free says a new beat may load this cycle.
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         l,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic         free
);
  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
      last  <= l;
    end else if (ready) begin
      // data is left as-is once drained; last must not linger on an empty stage
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end
endmodule

// File: rtl/frame_cipher_ctrl.sv
// Frame sequencer: header bytes pass through, pixel bytes are XORed with one keystream byte each.
module frame_cipher_ctrl import enc_pkg::*; #(
  parameter int HDR_BYTES = HDR_BYTES_DEF,
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 512,
  parameter int BPP       = 3,
  parameter int CW        = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  frame_cipher_ctrl_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       byte_cnt,
  output state_t              state
);
  localparam int          FRAME    = FRAME_BYTES(IMG_W, IMG_H, BPP, HDR_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
  localparam logic [CW-1:0] HDR_LAST = CW'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
  localparam state_t      FIRST    = (HDR_BYTES > 0) ? HDR : PIX;

  state_t        next_state;
  logic          free;
  logic          s_fire;
  logic          out_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          can_start;

  assign s_fire    = bus.s_tvalid && bus.s_tready;
  assign load_last = (byte_cnt == LAST_IDX);
  assign can_start = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = FIRST;
        HDR:        if (s_fire && byte_cnt == HDR_LAST) next_state = PIX;
        PIX:        if (s_fire && byte_cnt == LAST_IDX) next_state = DRAIN;
        DRAIN:      if (out_valid && bus.m_tready) next_state = DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  // In PIX each ready waits on the other side's valid so pixel and key always move together.
  always_comb begin
    bus.s_tready = 1'b0;
    bus.k_tready = 1'b0;
    load_data    = bus.s_tdata;
    if (!abort) begin
      case (state)
        HDR: bus.s_tready = free;
        PIX: begin
          bus.s_tready = free && bus.k_tvalid;
          bus.k_tready = free && bus.s_tvalid;
          load_data    = bus.s_tdata ^ bus.k_tdata;
        end
        default: ;
      endcase
    end
    busy = (state == HDR) || (state == PIX) || (state == DRAIN);
    done = !abort && (state == DRAIN) && out_valid && bus.m_tready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           byte_cnt <= '0;
    else if (abort)     byte_cnt <= '0;
    else if (can_start) byte_cnt <= '0;
    else if (s_fire)    byte_cnt <= byte_cnt + 1'b1;
  end

  axis_out_reg #(.W(DW)) u_out (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .load  (s_fire),
    .d     (load_data),
    .l     (load_last),
    .ready (bus.m_tready),
    .valid (out_valid),
    .data  (bus.m_tdata),
    .last  (bus.m_tlast),
    .free  (free)
  );

  assign bus.m_tvalid = out_valid;
endmodule

// File: tb/tb_frame_cipher_ctrl.sv
// Bench for frame_cipher_ctrl on a small 4-byte-header, 2x2x1 frame.
module tb_frame_cipher_ctrl;
  import enc_pkg::*;

  localparam int HDR   = 4;
  localparam int W     = 2;
  localparam int H     = 2;
  localparam int B     = 1;
  localparam int CW    = 20;
  localparam int FRAME = HDR + W * H * B;

  typedef struct packed {
    logic [7:0] din;
    logic [7:0] key;
    logic [7:0] dout;
    logic       last;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [CW-1:0] byte_cnt;
  state_t        dstate;

  frame_cipher_ctrl_if #(.WIDTH(8)) bus ();

  frame_cipher_ctrl #(
    .HDR_BYTES (HDR), .IMG_W (W), .IMG_H (H), .BPP (B), .CW (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .byte_cnt (byte_cnt),
    .state    (dstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] in_q[$];
  logic [7:0] key_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  vec_t       tbl[FRAME];

  int   cyc = 0;
  int   first_cyc, done_cyc, done_cnt, k_frame, k_hdr;
  logic mon_hs_s, mon_hs_k;
  logic prev_stall = 1'b0;
  logic prev_skip  = 1'b0;
  logic [8:0] prev_out = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, between drive (after posedge) and the next capturing edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      mon_hs_s = bus.s_tvalid && bus.s_tready;
      mon_hs_k = bus.k_tvalid && bus.k_tready;
      if (prev_stall && !prev_skip) begin
        check("hold_valid", bus.m_tvalid, 1);
        check("hold_data", {bus.m_tlast, bus.m_tdata}, prev_out);
      end
      if (dstate == PIX) check("join", mon_hs_k, mon_hs_s);
      else               check("no_key", mon_hs_k, 0);
      if (mon_hs_k) k_frame++;
      if (mon_hs_k && dstate == HDR) k_hdr++;
      if (mon_hs_s && first_cyc < 0) first_cyc = cyc;
      if (bus.m_tvalid && bus.m_tready) got_q.push_back({bus.m_tlast, bus.m_tdata});
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_out   = {bus.m_tlast, bus.m_tdata};
      prev_skip  = abort;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_tvalid"}, bus.m_tvalid, 0);
    check({tag, "_m_tdata"},  bus.m_tdata,  0);
    check({tag, "_m_tlast"},  bus.m_tlast,  0);
    check({tag, "_s_tready"}, bus.s_tready, 0);
    check({tag, "_k_tready"}, bus.k_tready, 0);
    check({tag, "_busy"},     busy,         0);
    check({tag, "_done"},     done,         0);
    check({tag, "_byte_cnt"}, byte_cnt,     0);
    check({tag, "_state"},    32'(dstate),  32'(IDLE));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference: header bytes copied, pixel i takes the i-th keystream byte, last on the final byte.
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < FRAME; i++)
      exp_q.push_back({(i == FRAME - 1), (i < HDR) ? in_q[i] : (in_q[i] ^ key_q[i - HDR])});
  endtask

  task automatic random_frame();
    in_q.delete();
    key_q.delete();
    for (int i = 0; i < FRAME; i++)       in_q.push_back(8'($urandom));
    for (int i = 0; i < FRAME - HDR; i++) key_q.push_back(8'($urandom));
  endtask

  task automatic run_frame(input int ps, input int pk, input int pm, input bit mid_start);
    int   si = 0;
    int   ki = 0;
    int   guard = 0;
    logic hs_s, hs_k;
    got_q.delete();
    k_frame = 0; k_hdr = 0; done_cnt = 0; first_cyc = -1; done_cyc = -1;
    pulse_start();
    while (done_cnt == 0 && guard < 2000) begin
      if (si < FRAME) begin
        if (!bus.s_tvalid) bus.s_tvalid = ($urandom_range(99) < ps);
        bus.s_tdata = in_q[si];
      end else bus.s_tvalid = 1'b0;
      if (ki < key_q.size()) begin
        if (!bus.k_tvalid) bus.k_tvalid = ($urandom_range(99) < pk);
        bus.k_tdata = key_q[ki];
      end else bus.k_tvalid = 1'b0;
      bus.m_tready = ($urandom_range(99) < pm);
      start = mid_start && (si == HDR + 1);
      @(negedge clk);
      hs_s = bus.s_tvalid && bus.s_tready;
      hs_k = bus.k_tvalid && bus.k_tready;
      @(posedge clk); #1;
      if (hs_s) begin si++; bus.s_tvalid = 1'b0; end
      if (hs_k) begin ki++; bus.k_tvalid = 1'b0; end
      guard++;
    end
    start = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.k_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    check({tag, "_keys"},     k_frame,  FRAME - HDR);
    check({tag, "_done"},     done_cnt, 1);
    check({tag, "_byte_cnt"}, byte_cnt, FRAME);
    check({tag, "_state"},    32'(dstate), 32'(DONE));
  endtask

  task automatic drive_until(input int cnt);
    int g = 0;
    pulse_start();
    bus.s_tvalid = 1'b1; bus.k_tvalid = 1'b1; bus.m_tready = 1'b1;
    while (byte_cnt != CW'(cnt) && g < 100) begin
      bus.s_tdata = 8'($urandom);
      bus.k_tdata = 8'($urandom);
      @(posedge clk); #1;
      g++;
    end
    check("reach_cnt", byte_cnt, cnt);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.s_tvalid = 1'b0; bus.s_tdata = '0;
    bus.k_tvalid = 1'b0; bus.k_tdata = '0;
    bus.m_tready = 1'b0;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Header passthrough then XOR; key column on header rows is offered but must not be used.
    tbl[0] = '{8'h42, 8'hFF, 8'h42, 1'b0};
    tbl[1] = '{8'h4D, 8'hFF, 8'h4D, 1'b0};
    tbl[2] = '{8'h36, 8'hFF, 8'h36, 1'b0};
    tbl[3] = '{8'h00, 8'hFF, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h0F, 8'h0F, 1'b0};
    tbl[5] = '{8'h55, 8'hF0, 8'hA5, 1'b0};
    tbl[6] = '{8'hAA, 8'h33, 8'h99, 1'b0};
    tbl[7] = '{8'hFF, 8'hCC, 8'h33, 1'b1};
    in_q.delete(); key_q.delete(); exp_q.delete();
    for (int i = 0; i < FRAME; i++) begin
      in_q.push_back(tbl[i].din);
      exp_q.push_back({tbl[i].last, tbl[i].dout});
      if (i >= HDR) key_q.push_back(tbl[i].key);
    end
    run_frame(100, 100, 100, 1'b0);
    compare_frame("table");
    check("hdr_keys", k_hdr, 0);
    check("throughput", done_cyc - first_cyc, FRAME);

    for (int f = 0; f < 6; f++) begin
      random_frame();
      build_model();
      run_frame(70, 60, 50, 1'b0);
      compare_frame("bp_frame");
    end

    random_frame();
    build_model();
    run_frame(80, 80, 80, 1'b1);
    compare_frame("start_in_pix");

    drive_until(6);
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1;
    bus.s_tvalid = 1'b0; bus.k_tvalid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_state",  32'(dstate), 32'(IDLE));
    check("abort_valid",  bus.m_tvalid, 0);
    check("abort_cnt",    byte_cnt, 0);
    check("abort_busy",   busy, 0);
    random_frame();
    build_model();
    run_frame(90, 90, 90, 1'b0);
    compare_frame("after_abort");

    drive_until(5);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    bus.s_tvalid = 1'b0; bus.k_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    random_frame();
    build_model();
    run_frame(75, 75, 60, 1'b0);
    compare_frame("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
